// File: rtl/ftq_read_arbiter_pkg.sv
// Shared backend definitions for the FTQ read-port arbiter: requester layout,
// default sizing and the request/response record types.
package ftq_read_arbiter_pkg;

    localparam int BRU_NUM            = 2;
    localparam int FTQRD_NREQ         = BRU_NUM + 1;
    localparam int FTQRD_ROB_REQ      = BRU_NUM;
    localparam int FTQRD_NPORT        = 2;
    localparam int FTQRD_IDX_W        = 4;
    localparam int FTQRD_XLEN         = 64;
    localparam int FTQRD_STARVE_LIMIT = 4;

    typedef struct packed {
        logic                   vld;
        logic [FTQRD_IDX_W-1:0] ftqIdx;
    } ftqRdReq_t;

    typedef struct packed {
        logic                  vld;
        logic [FTQRD_XLEN-1:0] startAddr;
        logic [FTQRD_XLEN-1:0] nextAddr;
    } ftqRdResp_t;

endpackage

// File: rtl/ftq_read_arbiter_rr.sv
// Combinational round-robin picker: grants up to 'slots' BRU requests starting
// at rr and reports the pointer one past the last BRU it granted.
module ftqrd_rr_picker
    import ftq_read_arbiter_pkg::*;
#(
    parameter int NB     = BRU_NUM,
    parameter int SLOT_W = 2,
    parameter int RR_W   = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic [NB-1:0]     req,
    input  logic [RR_W-1:0]   rr,
    input  logic [SLOT_W-1:0] slots,
    output logic [NB-1:0]     gnt,
    output logic [RR_W-1:0]   rr_next
);

    int used;

    always_comb begin
        gnt     = '0;
        rr_next = rr;
        used    = 0;
        for (int k = 0; k < NB; k++) begin
            for (int b = 0; b < NB; b++) begin
                if (b == (int'(rr) + k) % NB && req[b] && used < int'(slots)) begin
                    gnt[b]  = 1'b1;
                    used    = used + 1;
                    rr_next = RR_W'((b + 1) % NB);
                end
            end
        end
    end

endmodule

// File: rtl/ftq_read_arbiter.sv
// FTQ read-port arbiter: starved BRUs, then ROB, then round-robin BRUs fill the
// ports; indices are registered and read data routed back a cycle later.
// Optional perf counters are built when FTQRD_ARB_PERF_EN is defined.
module ftq_read_arbiter
    import ftq_read_arbiter_pkg::*;
#(
    parameter int NREQ         = FTQRD_NREQ,
    parameter int NPORT        = FTQRD_NPORT,
    parameter int FTQIDX_W     = FTQRD_IDX_W,
    parameter int XLEN         = FTQRD_XLEN,
    parameter int STARVE_LIMIT = FTQRD_STARVE_LIMIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_squash_vld,
    input  logic [NREQ-1:0]           i_req_vld,
    input  logic [NREQ*FTQIDX_W-1:0]  i_req_ftqIdx,
    output logic [NREQ-1:0]           o_req_gnt,
    output logic [NREQ-1:0]           o_resp_vld,
    output logic [NREQ*XLEN-1:0]      o_resp_startAddr,
    output logic [NREQ*XLEN-1:0]      o_resp_nextAddr,
    output logic [NPORT*FTQIDX_W-1:0] o_read_ftqIdx,
    input  logic [NPORT*XLEN-1:0]     i_read_ftqStartAddr,
    input  logic [NPORT*XLEN-1:0]     i_read_ftqNextAddr
`ifdef FTQRD_ARB_PERF_EN
    ,
    output logic [31:0]               o_perf_conflict_cnt,
    output logic [31:0]               o_perf_starve_cnt
`endif
);

    localparam int NB     = NREQ - 1;
    localparam int ROB    = NREQ - 1;
    localparam int RR_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int REQ_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SLOT_W = $clog2(NPORT + 1);
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

    logic [FTQIDX_W-1:0] req_idx    [NREQ];
    logic [NB-1:0]       bru_req, starve_gnt, rr_req, rr_gnt, gnt_bru;
    logic                rob_gnt;
    logic [SLOT_W-1:0]   pre_used, slots;
    logic [RR_W-1:0]     rr, rr_next;
    logic [CNT_W-1:0]    starve_cnt [NB];

    logic [NPORT-1:0]    port_vld, route_vld;
    logic [REQ_W-1:0]    port_req   [NPORT];
    logic [FTQIDX_W-1:0] port_idx   [NPORT];
    logic [REQ_W-1:0]    route_req  [NPORT];
    logic [FTQIDX_W-1:0] rd_idx     [NPORT];
    int                  fill;

    always_comb begin
        for (int r = 0; r < NREQ; r++) req_idx[r] = i_req_ftqIdx[r*FTQIDX_W +: FTQIDX_W];
    end

    // Squashed BRUs never reach the grant logic; the ROB is left alone.
    assign bru_req = i_req_vld[NB-1:0] & {NB{~i_squash_vld}};

    always_comb begin
        starve_gnt = '0;
        rob_gnt    = 1'b0;
        pre_used   = '0;
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                if (bru_req[b] && starve_cnt[b] == CNT_W'(STARVE_LIMIT) && pre_used < SLOT_W'(NPORT)) begin
                    starve_gnt[b] = 1'b1;
                    pre_used      = pre_used + SLOT_W'(1);
                end
            end
            if (i_req_vld[ROB] && pre_used < SLOT_W'(NPORT)) begin
                rob_gnt  = 1'b1;
                pre_used = pre_used + SLOT_W'(1);
            end
        end
        rr_req = rst ? (bru_req & ~starve_gnt) : '0;
        slots  = SLOT_W'(NPORT) - pre_used;
    end

    ftqrd_rr_picker #(.NB(NB), .SLOT_W(SLOT_W), .RR_W(RR_W)) u_rr_picker (
        .req     (rr_req),
        .rr      (rr),
        .slots   (slots),
        .gnt     (rr_gnt),
        .rr_next (rr_next)
    );

    assign gnt_bru   = starve_gnt | rr_gnt;
    assign o_req_gnt = {rob_gnt, gnt_bru};

    // Ports are handed out in priority order, so the first winner takes port 0.
    always_comb begin
        port_vld = '0;
        fill     = 0;
        for (int p = 0; p < NPORT; p++) begin
            port_req[p] = '0;
            port_idx[p] = '0;
        end
        for (int b = 0; b < NB; b++) begin
            if (starve_gnt[b]) begin
                for (int p = 0; p < NPORT; p++) begin
                    if (p == fill) begin
                        port_vld[p] = 1'b1;
                        port_req[p] = REQ_W'(b);
                        port_idx[p] = req_idx[b];
                    end
                end
                fill = fill + 1;
            end
        end
        if (rob_gnt) begin
            for (int p = 0; p < NPORT; p++) begin
                if (p == fill) begin
                    port_vld[p] = 1'b1;
                    port_req[p] = REQ_W'(ROB);
                    port_idx[p] = req_idx[ROB];
                end
            end
            fill = fill + 1;
        end
        for (int k = 0; k < NB; k++) begin
            for (int b = 0; b < NB; b++) begin
                if (b == (int'(rr) + k) % NB && rr_gnt[b]) begin
                    for (int p = 0; p < NPORT; p++) begin
                        if (p == fill) begin
                            port_vld[p] = 1'b1;
                            port_req[p] = REQ_W'(b);
                            port_idx[p] = req_idx[b];
                        end
                    end
                    fill = fill + 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr        <= '0;
            route_vld <= '0;
            for (int p = 0; p < NPORT; p++) begin
                route_req[p] <= '0;
                rd_idx[p]    <= '0;
            end
            for (int b = 0; b < NB; b++) starve_cnt[b] <= '0;
        end else begin
            rr        <= rr_next;
            route_vld <= port_vld;
            // Idle ports keep their last index to avoid toggling the FTQ read address.
            for (int p = 0; p < NPORT; p++) begin
                if (port_vld[p]) begin
                    route_req[p] <= port_req[p];
                    rd_idx[p]    <= port_idx[p];
                end
            end
            for (int b = 0; b < NB; b++) begin
                if (i_squash_vld || !i_req_vld[b] || gnt_bru[b]) begin
                    starve_cnt[b] <= '0;
                end else if (starve_cnt[b] != CNT_W'(STARVE_LIMIT)) begin
                    starve_cnt[b] <= starve_cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NPORT; p++) o_read_ftqIdx[p*FTQIDX_W +: FTQIDX_W] = rd_idx[p];
    end

    always_comb begin
        o_resp_vld       = '0;
        o_resp_startAddr = '0;
        o_resp_nextAddr  = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (route_vld[p] && route_req[p] == REQ_W'(r)) begin
                    o_resp_vld[r]                  = (r == ROB) || !i_squash_vld;
                    o_resp_startAddr[r*XLEN +: XLEN] = i_read_ftqStartAddr[p*XLEN +: XLEN];
                    o_resp_nextAddr[r*XLEN +: XLEN]  = i_read_ftqNextAddr[p*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef FTQRD_ARB_PERF_EN
    logic [32:0] conflict_sum, starve_sum;

    assign conflict_sum = {1'b0, o_perf_conflict_cnt} + 33'(|(i_req_vld & ~o_req_gnt));
    assign starve_sum   = {1'b0, o_perf_starve_cnt} + 33'($countones(starve_gnt));

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_perf_conflict_cnt <= '0;
            o_perf_starve_cnt   <= '0;
        end else begin
            o_perf_conflict_cnt <= conflict_sum[32] ? '1 : conflict_sum[31:0];
            o_perf_starve_cnt   <= starve_sum[32] ? '1 : starve_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/ftq_read_arbiter.md
Name: ftq_read_arbiter

Overview:
- Shares the FTQ read ports between the BRU pipes and the ROB commit path. Replaces the fixed "ROB overrides port 0" override in the backend top.
- Registered request/grant arbiter: grants up to NPORT requesters per cycle, drives FTQ read indices one cycle later and routes returned start/next addresses back to each granted requester.
- Sits in the backend between exeBlock/ctrlBlock and the FTQ read interface.

Parameters:
- NREQ, 3, requester count; indices 0..NREQ-2 are BRUs, index NREQ-1 is the ROB.
- NPORT, 2, FTQ read ports; 1 <= NPORT <= NREQ.
- FTQIDX_W, 4, ftqIdx width.
- XLEN, 64, address width.
- STARVE_LIMIT, 4, consecutive denied cycles before a BRU is promoted.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- i_squash_vld  in  1  backend squash.
- i_req_vld  in  NREQ  per-requester read request.
- i_req_ftqIdx  in  NREQ*FTQIDX_W  per-requester FTQ index; must be held stable while i_req_vld is high and o_req_gnt is low.
- o_req_gnt  out  NREQ  combinational grant, same cycle as the request.
- o_resp_vld  out  NREQ  response valid, one cycle after grant.
- o_resp_startAddr  out  NREQ*XLEN  routed FTQ start address.
- o_resp_nextAddr  out  NREQ*XLEN  routed FTQ next address.
- o_read_ftqIdx  out  NPORT*FTQIDX_W  FTQ read index, registered.
- i_read_ftqStartAddr  in  NPORT*XLEN  FTQ combinational read data.
- i_read_ftqNextAddr  in  NPORT*XLEN  FTQ combinational read data.

Behaviour:
- Reset (rst==0 at a clk edge):
  - o_read_ftqIdx = 0, o_resp_vld = 0, response route registers = 0.
  - Round-robin pointer rr = 0; all starvation counters = 0.
  - o_req_gnt = 0 while rst is low.
- Handshake:
  - A transfer occurs when i_req_vld[r] and o_req_gnt[r] are both high in cycle T.
  - Requester drops or changes its request only after the grant.
  - A request that is not granted stays pending, with no penalty.
- Grant order each cycle: fill up to NPORT slots, lowest free port first.
  1. Starved BRUs (counter == STARVE_LIMIT), lowest index first.
  2. ROB.
  3. Remaining BRUs in round-robin order starting at rr.
- rr update: rr becomes (last granted BRU index + 1) mod (NREQ-1). rr is unchanged if no BRU was granted through round-robin.
- Starvation counter, one per BRU:
  - +1 when i_req_vld & !o_req_gnt, saturating at STARVE_LIMIT.
  - Cleared on grant or when i_req_vld is low.
- Latency:
  - Grant in T: port p registers that requester's index and route; o_read_ftqIdx[p] is valid in T+1.
  - In T+1, o_resp_vld[r] = 1 and o_resp_* = i_read_ftq*[p], passed through combinationally.
  - Responses are in order per requester, single outstanding per requester per cycle.
- Idle port: o_read_ftqIdx[p] holds its last value to limit toggling; its route valid bit = 0.
- Squash, i_squash_vld in cycle T:
  - BRU grants forced to 0 in T.
  - BRU responses due in T (granted in T-1) have o_resp_vld suppressed.
  - All starvation counters cleared.
  - ROB request and response unaffected.
- Boundary cases:
  - NPORT >= number of requesters: every request granted.
  - No requests: all grants 0, counters clear.
  - Reset mid-transfer: any pending response is dropped; no o_resp_vld in the cycle after reset.

Optional Feature:
- FTQRD_ARB_PERF_EN defined:
  - Adds 32-bit saturating counters: o_perf_conflict_cnt (cycles with any denied request) and o_perf_starve_cnt (starvation promotions).
  - Both reset to 0.
- Undefined: these ports and counters are absent; arbitration behaviour is identical either way.

Decomposition:
- Backend shared package holds:
  - ftqRdReq_t {vld, ftqIdx}
  - ftqRdResp_t {vld, startAddr, nextAddr}
  - FTQRD_NREQ = BRU_NUM+1 and FTQRD_ROB_REQ = BRU_NUM
- One sub-module: ftqrd_rr_picker. It is combinational: it takes a request mask, rr and a slot count, and returns the grant mask and the new rr.

Test Plan:
- Only ROB requests idx 5 at T -> gnt[2]=1 at T; o_read_ftqIdx[0]=5 at T+1; o_resp_vld[2]=1 with start/next = port 0 data.
- BRU0, BRU1 and ROB all request at T, NPORT=2 -> ROB gets port 0 and BRU0 gets port 1 (rr=0); BRU1 granted at T+1; rr=0 afterwards.
- ROB and BRU0 request continuously with NPORT=1 -> BRU0 counter reaches 4 and BRU0 is granted in the 5th cycle ahead of the ROB; counter clears.
- BRU1 granted at T, i_squash_vld at T+1 -> o_resp_vld[1]=0 at T+1. BRU0 request at T+1 -> gnt 0. ROB granted at T+1 -> responds at T+2.
- Grant at T, rst low at T+1 -> no o_resp_vld at T+2; all outputs 0 at T+2.
- With FTQRD_ARB_PERF_EN, 3 cycles containing denials -> o_perf_conflict_cnt=3.
